and4_gate: RTL and testbench
============================

Name: and4_gate

Overview:
- Four-input AND primitive for glue logic and for building enable and qualifier terms.
- Provides a combinational output f = a & b & c & d, plus a registered copy f_q for timing-closed downstream use.
- Single clock domain. Synchronous, active-low reset.
- Operates bitwise over a parameterizable vector width. The default width of 1 is the plain 4-input gate.

Parameters:
- WIDTH, 1, bit width of each input and output. Legal range is 1 to 64. The operation is bitwise per lane.

Ports:
- clk  input  1  rising-edge clock; used only by the f_q register
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
- a  input  WIDTH  operand 0
- b  input  WIDTH  operand 1
- c  input  WIDTH  operand 2
- d  input  WIDTH  operand 3
- f  output  WIDTH  combinational result a & b & c & d
- f_q  output  WIDTH  result registered one clock after f

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- f is purely combinational. f[i] = a[i] & b[i] & c[i] & d[i] for every lane i.
  - f has zero latency and settles within the same time step as the input change.
  - f does not depend on clk or rst_n.
- Truth table per lane (WIDTH=1):
  - f=1 only for a=b=c=d=1.
  - All other 15 input combinations give f=0.
- f_q is updated on every rising edge of clk:
  - if rst_n==0, f_q <= 0 (all lanes);
  - else f_q <= a & b & c & d as sampled at that edge.
- Latency of f_q: 1 cycle. A value applied before edge N appears on f_q after edge N.
- Reset value of f_q: all zeros. f stays live during reset and keeps reflecting the inputs.
- Reset mid-operation:
  - On the first edge with rst_n low, f_q clears to 0.
  - On the first edge with rst_n high, f_q loads the current AND result. No extra dead cycle.
- rst_n asynchronously low between edges has no effect on f_q until the next rising edge.
- Lanes are fully independent. No cross-lane reduction and no carries.
- X/Z handling is standard 4-state AND semantics:
  - any operand 0 forces that lane to 0 regardless of the other operands being X;
  - otherwise X propagates.
- No internal state besides the f_q register. No handshake. Inputs are accepted every cycle.
- Power-up before the first reset edge: f_q is undefined. The design must be usable after one reset cycle.

Test Plan:
- Exhaustive combinational sweep, WIDTH=1:
  - apply all 16 combinations of {a,b,c,d} from 0000 to 1111, 10 ns apart;
  - f=0 for 0000 through 1110, and f=1 only for 1111.
- Registered path:
  - with rst_n=1, drive 1111 before edge 1 and 0111 before edge 2;
  - f_q=1 after edge 1 and 0 after edge 2, while f follows the inputs immediately.
- Synchronous reset:
  - hold inputs at 1111 and assert rst_n=0 for one edge: f_q=0 after that edge while f=1;
  - release rst_n: f_q=1 after the next edge.
- Reset sampling:
  - pulse rst_n low between edges only, never low at a rising edge;
  - f_q is unchanged, which proves reset is synchronous.
- Multi-lane, WIDTH=4:
  - drive a=1111, b=1011, c=1110, d=1111;
  - f=1010, and f_q=1010 one cycle later.
- X dominance:
  - drive a=0, b=X, c=1, d=1: f=0;
  - drive a=1, b=X, c=1, d=1: f=X.

Source files
------------

// File: rtl/and4_gate_if.sv
// Operand/result bundle for the and4_gate primitive.
// The master drives the four operands; the slave returns the combinational and registered results.
interface and4_gate_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_q;

    modport master (
        output a, b, c, d,
        input  f, f_q
    );

    modport slave (
        input  a, b, c, d,
        output f, f_q
    );
endinterface

// File: rtl/and4_gate.sv
// Bitwise four-input AND with a zero-latency output f and a one-cycle registered copy f_q.
// f_q clears on any rising edge that samples rst_n low; f stays live throughout reset.
module and4_gate #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    and4_gate_if.slave  bus
);
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("and4_gate: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] f_q;

    assign f_d = bus.a & bus.b & bus.c & bus.d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign bus.f   = f_d;
    assign bus.f_q = f_q;
endmodule

// File: tb/tb_and4_gate.sv
// Directed bench for and4_gate: single-lane gate plus a 4-lane instance on a shared clock and reset.
module tb_and4_gate;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    and4_gate_if #(.WIDTH(1)) if1 ();
    and4_gate_if #(.WIDTH(4)) if4 ();

    and4_gate #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    and4_gate #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic [3:0] abcd);
        if1.a = abcd[3];
        if1.b = abcd[2];
        if1.c = abcd[1];
        if1.d = abcd[0];
    endtask

    initial begin
        logic [3:0] vec;
        logic       exp_x;

        drive1(4'b1111);
        if4.a = 4'b0000;
        if4.b = 4'b0000;
        if4.c = 4'b0000;
        if4.d = 4'b0000;

        // Reset for two edges: f_q cleared, f still live
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fq1", {3'b0, if1.f_q}, 4'b0000);
        chk("reset_f1_live", {3'b0, if1.f}, 4'b0001);
        chk("reset_fq4", if4.f_q, 4'b0000);

        // Exhaustive combinational sweep, 10 ns apart
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vec = 4'(i);
            drive1(vec);
            #1;
            chk($sformatf("sweep_%0d", i), {3'b0, if1.f}, (i == 15) ? 4'b0001 : 4'b0000);
            #9;
        end

        // Registered path: 1111 then 0111
        @(negedge clk);
        drive1(4'b1111);
        #1;
        chk("reg_f_1111", {3'b0, if1.f}, 4'b0001);
        @(posedge clk);
        #1;
        chk("reg_fq_edge1", {3'b0, if1.f_q}, 4'b0001);
        drive1(4'b0111);
        #1;
        chk("reg_f_0111", {3'b0, if1.f}, 4'b0000);
        chk("reg_fq_holds", {3'b0, if1.f_q}, 4'b0001);
        @(posedge clk);
        #1;
        chk("reg_fq_edge2", {3'b0, if1.f_q}, 4'b0000);

        // Synchronous reset with inputs held high
        @(negedge clk);
        drive1(4'b1111);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("srst_fq", {3'b0, if1.f_q}, 4'b0000);
        chk("srst_f", {3'b0, if1.f}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("srst_release_fq", {3'b0, if1.f_q}, 4'b0001);

        // Reset pulse between edges only
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("pulse_fq_during", {3'b0, if1.f_q}, 4'b0001);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pulse_fq_after_edge", {3'b0, if1.f_q}, 4'b0001);

        // Multi-lane
        @(negedge clk);
        if4.a = 4'b1111;
        if4.b = 4'b1011;
        if4.c = 4'b1110;
        if4.d = 4'b1111;
        #1;
        chk("lanes_f", if4.f, 4'b1010);
        @(posedge clk);
        #1;
        chk("lanes_fq", if4.f_q, 4'b1010);
        @(negedge clk);
        if4.b = 4'b0101;
        #1;
        chk("lanes_f2", if4.f, 4'b0100);
        @(posedge clk);
        #1;
        chk("lanes_fq2", if4.f_q, 4'b0100);

        // X dominance: a zero operand forces the lane low
        @(negedge clk);
        if1.a = 1'b0;
        if1.b = 1'bx;
        if1.c = 1'b1;
        if1.d = 1'b1;
        #1;
        chk("x_zero_dominates", {3'b0, if1.f}, 4'b0000);
        if1.a = 1'b1;
        #1;
        exp_x = if1.a & if1.b & if1.c & if1.d;
        chk("x_propagates", {3'b0, if1.f}, {3'b0, exp_x});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
